// File: rtl/cpu_pkg.sv
// Shared CPU types: register/data widths and the write-back entry used by
// the write-back arbiter and its result FIFO.
package cpu_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int DATA_W      = 32;
    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Which producer owns the write-back port for the coming cycle.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_ALU    = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of buffered MDU results. DEPTH must be a power of two
// (2 or 4) so the pointers wrap naturally.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      Clk,
    input  logic      Reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t push_entry,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Guards keep the count from ever wrapping, whatever the caller asks for.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: storage is not reset; an empty count makes stale entries unreachable.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results take priority, MDU results queue behind
// them in wb_fifo, and a busy scoreboard tracks pending MDU writes.
// Optional stall counter enabled with `define WB_PERF_EN.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  AluValid,
    input  logic [REG_ADDR_W-1:0] AluRd,
    input  logic [DATA_W-1:0]     AluData,
    input  logic                  MduValid,
    input  logic [REG_ADDR_W-1:0] MduRd,
    input  logic [DATA_W-1:0]     MduData,
    output logic                  MduReady,
    input  logic                  IssueMdu,
    input  logic [REG_ADDR_W-1:0] IssueRd,
    output logic [31:0]           Busy,
    output logic [REG_ADDR_W-1:0] RD,
    output logic [DATA_W-1:0]     WData,
    output logic                  RegWr
`ifdef WB_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] StallCnt
`endif
);

    wb_entry_t             fifo_head;
    logic                  fifo_full, fifo_empty;
    logic                  fifo_push, fifo_pop;
    logic                  mdu_fire;
    wb_src_e               src;
    wb_entry_t             sel_entry;
    logic [31:0]           set_mask, clr_mask;

    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  reg_wr_q, reg_wr_d;
    logic [31:0]           busy_q, busy_d;

    // Ready depends on the FIFO count alone, never on AluValid.
    assign MduReady = ~fifo_full;
    assign mdu_fire = MduValid & ~fifo_full;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk        (Clk),
        .Reset      (Reset),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .push_entry ('{rd: MduRd, data: MduData}),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        src       = SRC_NONE;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (AluValid) begin
            src       = SRC_ALU;
            fifo_push = mdu_fire;
        end else if (!fifo_empty) begin
            src       = SRC_FIFO;
            fifo_pop  = 1'b1;
            fifo_push = mdu_fire;
        end else if (mdu_fire) begin
            src = SRC_BYPASS;
        end
    end

    always_comb begin
        sel_entry = '{rd: AluRd, data: AluData};
        rd_d      = rd_q;
        wdata_d   = wdata_q;
        reg_wr_d  = 1'b0;
        clr_mask  = '0;
        set_mask  = '0;
        case (src)
            SRC_FIFO:   sel_entry = fifo_head;
            SRC_BYPASS: sel_entry = '{rd: MduRd, data: MduData};
            default:    sel_entry = '{rd: AluRd, data: AluData};
        endcase
        if (src != SRC_NONE) begin
            rd_d     = sel_entry.rd;
            wdata_d  = sel_entry.data;
            reg_wr_d = (sel_entry.rd != '0);
        end
        if (src == SRC_FIFO || src == SRC_BYPASS) begin
            clr_mask[sel_entry.rd] = 1'b1;
        end
        if (IssueMdu && IssueRd != '0) begin
            set_mask[IssueRd] = 1'b1;
        end
        // Set is applied after clear so a same-edge reissue keeps the bit.
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_q     <= '0;
            wdata_q  <= '0;
            reg_wr_q <= 1'b0;
            busy_q   <= '0;
        end else begin
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            reg_wr_q <= reg_wr_d;
            busy_q   <= busy_d;
        end
    end

    assign RD    = rd_q;
    assign WData = wdata_q;
    assign RegWr = reg_wr_q;
    assign Busy  = busy_q;

`ifdef WB_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (AluValid && !fifo_empty && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based reference model checked
// every cycle, plus hand-computed literal checks for the directed scenarios.
module tb_wb_arbiter;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        AluValid, MduValid, IssueMdu;
    logic [4:0]  AluRd, MduRd, IssueRd;
    logic [31:0] AluData, MduData;
    logic        MduReady, RegWr;
    logic [31:0] Busy, WData;
    logic [4:0]  RD;
`ifdef WB_PERF_EN
    logic [15:0] StallCnt;
`endif

    always #5 Clk = ~Clk;

    wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .AluValid (AluValid),
        .AluRd    (AluRd),
        .AluData  (AluData),
        .MduValid (MduValid),
        .MduRd    (MduRd),
        .MduData  (MduData),
        .MduReady (MduReady),
        .IssueMdu (IssueMdu),
        .IssueRd  (IssueRd),
        .Busy     (Busy),
        .RD       (RD),
        .WData    (WData),
        .RegWr    (RegWr)
`ifdef WB_PERF_EN
        ,
        .StallCnt (StallCnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: pending MDU results as a queue, outputs as plain variables.
    wb_entry_t   mq[$];
    logic        m_regwr = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_busy = '0;
    int          m_stall = 0;
    bit          m_accept, m_have, m_from_mdu;
    wb_entry_t   m_w;

    always @(posedge Clk) begin
        if (Reset) begin
            mq.delete();
            m_regwr = 1'b0;
            m_rd    = '0;
            m_wdata = '0;
            m_busy  = '0;
            m_stall = 0;
        end else begin
            m_accept   = MduValid && (mq.size() < DEPTH);
            m_have     = 1'b0;
            m_from_mdu = 1'b0;
            m_w        = '{rd: AluRd, data: AluData};
            if (AluValid && mq.size() > 0 && m_stall < 65535) m_stall++;
            if (AluValid) begin
                m_have = 1'b1;
            end else if (mq.size() > 0) begin
                m_w        = mq.pop_front();
                m_have     = 1'b1;
                m_from_mdu = 1'b1;
            end else if (m_accept) begin
                m_w        = '{rd: MduRd, data: MduData};
                m_have     = 1'b1;
                m_from_mdu = 1'b1;
                m_accept   = 1'b0;
            end
            if (m_accept) mq.push_back('{rd: MduRd, data: MduData});
            m_regwr = m_have && (m_w.rd != 0);
            if (m_have) begin
                m_rd    = m_w.rd;
                m_wdata = m_w.data;
            end
            if (m_from_mdu) m_busy[m_w.rd] = 1'b0;
            if (IssueMdu && IssueRd != 0) m_busy[IssueRd] = 1'b1;
        end
    end

    always @(negedge Clk) begin
        check("model_ready", 32'(MduReady), 32'(mq.size() < DEPTH));
        check("model_regwr", 32'(RegWr), 32'(m_regwr));
        if (m_regwr) begin
            check("model_rd", 32'(RD), 32'(m_rd));
            check("model_wdata", WData, m_wdata);
        end
        check("model_busy", Busy, m_busy);
`ifdef WB_PERF_EN
        check("model_stall", 32'(StallCnt), 32'(m_stall));
`endif
    end

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    task automatic idle();
        AluValid = 1'b0; AluRd = '0; AluData = '0;
        MduValid = 1'b0; MduRd = '0; MduData = '0;
        IssueMdu = 1'b0; IssueRd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        Reset = 1'b1;
        tick();
        tick();
        check("rst_regwr", 32'(RegWr), 32'd0);
        check("rst_rd", 32'(RD), 32'd0);
        check("rst_wdata", WData, 32'd0);
        check("rst_busy", Busy, 32'd0);
        check("rst_ready", 32'(MduReady), 32'd1);
        Reset = 1'b0;
        tick();

        // ALU write, one-cycle latency
        AluValid = 1'b1; AluRd = 5'd5; AluData = 32'h1234;
        tick();
        idle();
        check("alu_regwr", 32'(RegWr), 32'd1);
        check("alu_rd", 32'(RD), 32'd5);
        check("alu_wdata", WData, 32'h1234);

        // MDU issue then bypass write clears busy
        IssueMdu = 1'b1; IssueRd = 5'd7;
        tick();
        idle();
        check("busy7_set", 32'(Busy[7]), 32'd1);
        MduValid = 1'b1; MduRd = 5'd7; MduData = 32'hCAFE;
        tick();
        idle();
        check("byp_rd", 32'(RD), 32'd7);
        check("byp_wdata", WData, 32'hCAFE);
        check("byp_regwr", 32'(RegWr), 32'd1);
        check("busy7_clr", 32'(Busy[7]), 32'd0);

        // ALU burst of 4 while MDU offers 8, 9, 10
        for (int r = 8; r <= 10; r++) begin
            IssueMdu = 1'b1; IssueRd = 5'(r);
            tick();
        end
        idle();
        for (int c = 0; c < 4; c++) begin
            AluValid = 1'b1; AluRd = 5'(20 + c); AluData = 32'(100 + c);
            MduValid = 1'b1;
            MduRd    = (c == 0) ? 5'd8 : (c == 1) ? 5'd9 : 5'd10;
            MduData  = 32'h800 + 32'(MduRd);
            tick();
            if (c == 1) check("burst_ready_low", 32'(MduReady), 32'd0);
        end
        check("burst_last_rd", 32'(RD), 32'd23);
        AluValid = 1'b0;
        tick();
        check("drain8_rd", 32'(RD), 32'd8);
        check("drain8_ready", 32'(MduReady), 32'd1);
        tick();
        MduValid = 1'b0;
        check("drain9_rd", 32'(RD), 32'd9);
        tick();
        check("drain10_rd", 32'(RD), 32'd10);
        check("drain10_wdata", WData, 32'h80A);
        check("busy10_clr", 32'(Busy[10]), 32'd0);
        idle();

        // rd=0 retirement: bypass, then through the FIFO
        MduValid = 1'b1; MduRd = 5'd0; MduData = 32'hFFFF;
        tick();
        idle();
        check("rd0_byp_regwr", 32'(RegWr), 32'd0);
        AluValid = 1'b1; AluRd = 5'd1; AluData = 32'h11;
        MduValid = 1'b1; MduRd = 5'd0; MduData = 32'hFFFF;
        tick();
        MduRd = 5'd13; MduData = 32'h1313;
        tick();
        idle();
        tick();
        check("rd0_fifo_regwr", 32'(RegWr), 32'd0);
        tick();
        check("rd0_adv_rd", 32'(RD), 32'd13);
        check("rd0_adv_regwr", 32'(RegWr), 32'd1);

        // reissue of rd3 in the same cycle it retires
        IssueMdu = 1'b1; IssueRd = 5'd3;
        tick();
        MduValid = 1'b1; MduRd = 5'd3; MduData = 32'h33;
        tick();
        idle();
        check("reissue_rd", 32'(RD), 32'd3);
        check("reissue_busy3", 32'(Busy[3]), 32'd1);

        // reset with two pending entries
        IssueMdu = 1'b1; IssueRd = 5'd11;
        tick();
        IssueRd = 5'd12;
        tick();
        idle();
        AluValid = 1'b1; AluRd = 5'd2; AluData = 32'h2;
        MduValid = 1'b1; MduRd = 5'd11; MduData = 32'hB;
        tick();
        MduRd = 5'd12; MduData = 32'hC;
        tick();
        idle();
        check("pend_ready_low", 32'(MduReady), 32'd0);
        Reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(MduReady), 32'd1);
        check("mid_rst_busy", Busy, 32'd0);
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_regwr", 32'(RegWr), 32'd0);
        end

        // mixed traffic, checked by the model every cycle
        for (int i = 0; i < 48; i++) begin
            AluValid = (i % 3 == 0);
            AluRd    = 5'(i);
            AluData  = 32'(i * 17);
            MduValid = (i % 4 != 3);
            MduRd    = 5'((i * 7) % 32);
            MduData  = 32'hA000 + 32'(i);
            IssueMdu = (i % 5 == 1);
            IssueRd  = 5'((i * 3) % 32);
            tick();
        end
        idle();
        for (int c = 0; c < 4; c++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: number of MDU result entries buffered, legal values 2 or 4.
REQ-002 SHALL have port Clk  in  1: rising-edge clock.
REQ-003 SHALL have port Reset  in  1: reset, asynchronous, active-high.
REQ-004 SHALL have port AluValid  in  1: single-cycle ALU/load result present this cycle.
REQ-005 SHALL have port AluRd  in  5: destination register of the ALU result.
REQ-006 SHALL have port AluData  in  32: ALU result value.
REQ-007 SHALL have port MduValid  in  1: multiply/divide result offered.
REQ-008 SHALL have port MduRd  in  5: MDU destination register.
REQ-009 SHALL have port MduData  in  32: MDU result value.
REQ-010 SHALL have port MduReady  out  1: MDU result accepted this cycle; the transfer occurs when MduValid and MduReady are both 1.
REQ-011 SHALL have port IssueMdu  in  1: an MDU operation is issued this cycle.
REQ-012 SHALL have port IssueRd  in  5: destination register of the issued MDU operation.
REQ-013 SHALL have port Busy  out  32: per-register pending-MDU-write scoreboard.
REQ-014 SHALL have port RD  out  5: register-file write address.
REQ-015 SHALL have port WData  out  32: register-file write data.
REQ-016 SHALL have port RegWr  out  1: register-file write enable.

Function
REQ-017 SHALL drive RD, WData and RegWr from flops; at most one write is issued per cycle.
REQ-018 SHALL give the ALU absolute priority: when AluValid=1 at edge N, RD=AluRd, WData=AluData and RegWr=1 are driven after edge N, giving 1-cycle latency.
REQ-019 SHALL buffer MDU results in an in-order FIFO of FIFO_DEPTH entries; MduReady is 1 exactly when the FIFO is not full, decided combinationally from the FIFO count only.
REQ-020 SHALL send an accepted MDU result straight to the output flops (bypassing the FIFO) when the FIFO is empty and AluValid=0; otherwise the result is enqueued.
REQ-021 SHALL write the FIFO head to the output at edge N when AluValid=0 at that edge, and may enqueue a new MDU result in the same cycle.
REQ-022 SHALL hold the FIFO contents unchanged at every edge where AluValid=1, except for enqueueing a result that is accepted that cycle.
REQ-023 SHALL treat any write with destination 0 as a retirement with RegWr=0; the FIFO still advances and the scoreboard is still updated.
REQ-024 SHALL set Busy[IssueRd] at the edge where IssueMdu=1 and IssueRd!=0; Busy[0] is constant 0.
REQ-025 SHALL clear Busy[RD] at the edge that loads an MDU result into the output flops.
REQ-026 SHALL let set win when a set and a clear hit the same register at the same edge.
REQ-027 SHALL NOT allow the FIFO count to wrap: with the FIFO full, MduReady=0 and no MDU transfer occurs; with the FIFO empty, no dequeue occurs.

Reset
REQ-028 SHALL, while Reset is asserted, force RegWr=0, RD=0, WData=0, Busy=0 and empty the FIFO (MduReady=1).
REQ-029 SHALL discard all in-flight buffered results when Reset is asserted mid-operation, without writing any of them.

Configuration
REQ-030 SHALL, when WB_PERF_EN is defined, add output StallCnt (16 bits), reset to 0, which increments in every cycle where the FIFO is non-empty and AluValid=1 and saturates at 16'hFFFF.
REQ-031 SHALL omit StallCnt and all of its logic when WB_PERF_EN is undefined; all other behaviour is identical with or without the macro.

Structure
REQ-032 SHALL take REG_ADDR_W=5, DATA_W=32 and a wb_entry_t struct {rd, data} from the shared package cpu_pkg.
REQ-033 SHALL place the FIFO (storage, pointers, count, full/empty) in sub-module wb_fifo; arbitration and the scoreboard live in wb_arbiter.

Verification
REQ-034 SHALL verify: AluValid=1, AluRd=5, AluData=32'h1234 at edge 1 -> RegWr=1, RD=5, WData=32'h1234 after edge 1.
REQ-035 SHALL verify: IssueMdu with IssueRd=7, then the MDU result rd=7, data=32'hCAFE offered with AluValid=0 and the FIFO empty -> Busy[7]=1 until the edge that writes RD=7, then Busy[7]=0.
REQ-036 SHALL verify: AluValid=1 for 4 cycles while MDU offers results to rd=8, 9, 10 -> MduReady falls after 2 accepts; writes to 8 and 9 follow the ALU burst in order; 10 is accepted once space frees.
REQ-037 SHALL verify: MDU result rd=0, data=32'hFFFF -> RegWr=0 and the FIFO advances.
REQ-038 SHALL verify: IssueMdu with IssueRd=3 in the same cycle as the retire of an MDU result to register 3 -> Busy[3]=1 after that edge.
REQ-039 SHALL verify: Reset pulsed with 2 FIFO entries pending -> MduReady=1, Busy=0, and no subsequent RegWr for the discarded entries.
